// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed common-anode seven-segment scan driver
module seg_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYC    = 16,
  parameter int FLASH_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [4*DIGITS-1:0]   ext,
  input  logic [DIGITS-1:0]     dp,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick,
  output logic                  flash_phase
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(FLASH_FRAMES - 1);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [FW-1:0] frame_cnt;

  logic [3:0] data_sh [DIGITS];
  logic [3:0] ext_sh  [DIGITS];
  logic       dp_sh   [DIGITS];

  logic       in_blank;
  logic       wrap_slot;
  logic       wrap_frame;
  logic [3:0] cur_ext;
  logic [7:0] glyph;

  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 8'hC0;
      4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;
      4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;
      4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;
      4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;
      4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;
      4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;
      default: hex7 = 8'h8E;
    endcase
  endfunction

  // A zero-length blanking window must not produce an always-false compare.
  generate
    if (BLANK_CYC == 0) begin : g_noblank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = cnt < CW'(BLANK_CYC);
    end
  endgenerate

  assign wrap_slot  = (cnt == CNT_MAX);
  assign wrap_frame = wrap_slot && (idx == IDX_MAX);

  always_comb begin
    cur_ext = ext_sh[idx];
    glyph   = 8'hFF;
    case (cur_ext[2:0])
      3'b000:  glyph = hex7(data_sh[idx]);
      3'b001:  glyph = 8'hBF;
      3'b010:  glyph = 8'hF7;
      default: glyph = 8'hFF;
    endcase
    if (dp_sh[idx] && (cur_ext[2:0] <= 3'd2)) glyph[7] = 1'b0;
    if (cur_ext[3] && flash_phase) glyph = 8'hFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      flash_phase <= 1'b0;
      frame_tick  <= 1'b0;
      an          <= '1;
      seg         <= 8'hFF;
    end else if (!en) begin
      cnt        <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
      an         <= '1;
      seg        <= 8'hFF;
    end else begin
      an         <= in_blank ? '1 : ~(DIGITS'(1) << idx);
      seg        <= in_blank ? 8'hFF : glyph;
      frame_tick <= wrap_frame;
      if (wrap_slot) begin
        cnt <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (wrap_frame) begin
        if (frame_cnt == FRM_MAX) begin
          frame_cnt   <= '0;
          flash_phase <= ~flash_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  // Shadow registers load independently of en so the CPU can preload while blanked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) begin
        data_sh[i] <= 4'h0;
        ext_sh[i]  <= 4'b0111;
        dp_sh[i]   <= 1'b0;
      end
    end else if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        data_sh[i] <= data[4*i +: 4];
        ext_sh[i]  <= ext[4*i +: 4];
        dp_sh[i]   <= dp[i];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

  localparam int DG = 4;
  localparam int SD = 4;
  localparam int BC = 1;
  localparam int FF = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          load;
  logic [15:0]   data;
  logic [15:0]   ext;
  logic [3:0]    dp;
  logic [7:0]    seg;
  logic [3:0]    an;
  logic          frame_tick;
  logic          flash_phase;

  seg_scan_driver #(
    .DIGITS(DG), .SCAN_DIV(SD), .BLANK_CYC(BC), .FLASH_FRAMES(FF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load),
    .data(data), .ext(ext), .dp(dp),
    .seg(seg), .an(an), .frame_tick(frame_tick), .flash_phase(flash_phase)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [3:0] tp1_seq [8] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD};

  // Reference model: position in the scan as an absolute enabled-cycle count.
  int         m_pos;
  int         m_frames;
  int         m_data [DG];
  int         m_ext  [DG];
  int         m_dp   [DG];
  logic [3:0] e_an;
  logic [7:0] e_seg;
  logic       e_tick;

  function automatic void model_reset();
    m_pos    = 0;
    m_frames = 0;
    for (int i = 0; i < DG; i++) begin
      m_data[i] = 0;
      m_ext[i]  = 7;
      m_dp[i]   = 0;
    end
    e_an   = 4'hF;
    e_seg  = 8'hFF;
    e_tick = 1'b0;
  endfunction

  function automatic int model_phase();
    return (m_frames / FF) % 2;
  endfunction

  function automatic logic [7:0] model_glyph(int d, int ph);
    int         mode;
    logic [7:0] g;
    mode = m_ext[d] % 8;
    if (mode == 0)      g = hex_tab[m_data[d]];
    else if (mode == 1) g = 8'hBF;
    else if (mode == 2) g = 8'hF7;
    else                g = 8'hFF;
    if (mode <= 2 && m_dp[d] != 0) g = g & 8'h7F;
    if (m_ext[d] >= 8 && ph != 0) g = 8'hFF;
    return g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    int c, d, ph;
    @(posedge clk);
    ph = model_phase();
    if (!en) begin
      e_an   = 4'hF;
      e_seg  = 8'hFF;
      e_tick = 1'b0;
      m_pos  = 0;
    end else begin
      c = m_pos % SD;
      d = (m_pos / SD) % DG;
      if (c < BC) begin
        e_an  = 4'hF;
        e_seg = 8'hFF;
      end else begin
        e_an  = 4'hF ^ (4'b0001 << d);
        e_seg = model_glyph(d, ph);
      end
      e_tick = (m_pos % (SD * DG)) == (SD * DG - 1);
      if (e_tick) m_frames++;
      m_pos++;
    end
    if (load) begin
      for (int i = 0; i < DG; i++) begin
        m_data[i] = int'(data[4*i +: 4]);
        m_ext[i]  = int'(ext[4*i +: 4]);
        m_dp[i]   = int'(dp[i]);
      end
    end
    #1;
    chk("an", an, e_an);
    chk("seg", seg, e_seg);
    chk("frame_tick", frame_tick, e_tick);
    chk("flash_phase", flash_phase, model_phase());
  endtask

  initial begin
    int guard;
    int saved_ph;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; data = '0; ext = '0; dp = '0;
    model_reset();

    // Reset held with clock running
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_tick", frame_tick, 1'b0);
    chk("rst_phase", flash_phase, 1'b0);

    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("tp1_an", an, tp1_seq[i]);
      chk("tp1_seg", seg, 8'hFF);
    end

    // Hex decode with decimal point on digit 2
    data = 16'h3A90; ext = 16'h0000; dp = 4'b0100; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      case (e_an)
        4'hE: chk("tp2_d0", seg, 8'hC0);
        4'hD: chk("tp2_d1", seg, 8'h90);
        4'hB: chk("tp2_d2", seg, 8'h08);
        4'h7: chk("tp2_d3", seg, 8'hB0);
        default: ;
      endcase
    end

    // Glyph modes
    ext = 16'h7210; dp = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      case (e_an)
        4'hD: chk("tp3_minus", seg, 8'hBF);
        4'hB: chk("tp3_under", seg, 8'hF7);
        4'h7: chk("tp3_blank", seg, 8'hFF);
        default: ;
      endcase
    end

    // Flash on digit 1
    data = 16'h0050; ext = 16'h0080; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (e_an == 4'hD) chk("tp4_flash", seg, (model_phase() != 0) ? 8'hFF : 8'h92);
    end

    // Drop enable during digit 2
    guard = 0;
    while (!(((m_pos / SD) % DG) == 2 && (m_pos % SD) == 2) && guard < 64) begin
      tick();
      guard++;
    end
    chk("tp5_reach_d2", guard < 64, 1'b1);
    saved_ph = model_phase();
    en = 1'b0;
    tick();
    chk("tp5_off_an", an, 4'hF);
    repeat (4) tick();
    chk("tp5_phase_hold", flash_phase, saved_ph);
    en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("tp5_restart_d1", an, 4'hD);

    // Mid-slot load
    data = 16'h1111; ext = 16'h0000; dp = 4'b1111; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (8) tick();

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("tp6_an", an, 4'hF);
    chk("tp6_seg", seg, 8'hFF);
    chk("tp6_phase", flash_phase, 1'b0);
    chk("tp6_tick", frame_tick, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("tp6_shadow_blank", seg, 8'hFF);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      load = ($urandom % 6) == 0;
      data = 16'($urandom);
      ext  = 16'($urandom);
      dp   = 4'($urandom);
      en   = ($urandom % 25) != 0;
      tick();
    end
    load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
